// File: rtl/cl_mem_access_pkg.sv
// Shared types for the data-memory access controller: the decoded control
// bundle, the access FSM states and the byte-lane geometry.
package cl_mem_access_pkg;

  localparam int kBYTE_LANES = 4;

  // Decoded control bundle handed over from the decode/execute stages.
  typedef struct packed {
    logic is_load_op_c;
    logic op_writes_rf_c;
    logic is_mem_op_c;
    logic is_store_op_c;
    logic is_byte_op_c;
  } ctrl_sigs;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ERR
  } mem_state_e;

  // Byte-lane write enables: one lane for byte stores, all lanes for words.
  function automatic logic [kBYTE_LANES-1:0] lane_mask(input logic       is_byte,
                                                       input logic [1:0] lane);
    logic [kBYTE_LANES-1:0] one_lane;
    one_lane = 4'b0001;
    return is_byte ? (one_lane << lane) : {kBYTE_LANES{1'b1}};
  endfunction

endpackage

// File: rtl/cl_mem_access_byte_lane.sv
// Byte-lane steering: store data replication and mask generation, and
// little-endian byte extraction with zero-extension for loads.
module mem_byte_lane
  import cl_mem_access_pkg::*;
(
  input  logic                   is_byte_i,
  input  logic [1:0]             lane_i,
  input  logic [31:0]            store_data_i,
  input  logic [31:0]            load_word_i,
  output logic [31:0]            wdata_o,
  output logic [kBYTE_LANES-1:0] mask_o,
  output logic [31:0]            load_data_o
);

  logic [7:0] load_byte;

  // Steer store data onto lanes and pick the addressed load byte.
  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    wdata_o = is_byte_i ? {kBYTE_LANES{store_data_i[7:0]}} : store_data_i;
    mask_o  = lane_mask(is_byte_i, lane_i);
    case (lane_i)
      2'd0:    load_byte = load_word_i[7:0];
      2'd1:    load_byte = load_word_i[15:8];
      2'd2:    load_byte = load_word_i[23:16];
      default: load_byte = load_word_i[31:24];
    endcase
    load_data_o = is_byte_i ? {24'd0, load_byte} : load_word_i;
  end

endmodule

// File: rtl/cl_mem_access.sv
// Data-memory access controller between execute and writeback. Accepts one
// memory instruction, issues it over a valid/ready request port, waits for
// the load response and returns the lane-extracted result as a wb pulse.
module cl_mem_access
  import cl_mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  ctrl_sigs                 ctrl_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]    store_data_i,
  input  logic [RF_ADDR_WIDTH-1:0] rd_i,
  output logic                     stall_o,
  output logic                     dmem_req_valid_o,
  input  logic                     dmem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]    dmem_addr_o,
  output logic                     dmem_wen_o,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
  output logic [kBYTE_LANES-1:0]   dmem_mask_o,
  input  logic                     dmem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]    dmem_resp_data_i,
  output logic                     wb_valid_o,
  output logic [RF_ADDR_WIDTH-1:0] wb_rd_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  output logic                     misalign_o
);

  mem_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    store_data_q, store_data_d;
  logic [RF_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                     is_store_q, is_store_d;
  logic                     is_load_q, is_load_d;
  logic                     writes_rf_q, writes_rf_d;
  logic                     is_byte_q, is_byte_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [RF_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;

  logic                     accept;
  logic [DATA_WIDTH-1:0]    lane_wdata;
  logic [kBYTE_LANES-1:0]   lane_mask_w;
  logic [DATA_WIDTH-1:0]    load_data;

  assign accept = valid_i && ctrl_i.is_mem_op_c;

  mem_byte_lane u_byte_lane (
    .is_byte_i    (is_byte_q),
    .lane_i       (addr_q[1:0]),
    .store_data_i (store_data_q),
    .load_word_i  (dmem_resp_data_i),
    .wdata_o      (lane_wdata),
    .mask_o       (lane_mask_w),
    .load_data_o  (load_data)
  );

  // Next-state and capture logic for the access FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    is_store_d   = is_store_q;
    is_load_d    = is_load_q;
    writes_rf_d  = writes_rf_q;
    is_byte_d    = is_byte_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d       = addr_i;
          store_data_d = store_data_i;
          rd_d         = rd_i;
          is_store_d   = ctrl_i.is_store_op_c;
          is_load_d    = ctrl_i.is_load_op_c;
          writes_rf_d  = ctrl_i.op_writes_rf_c;
          is_byte_d    = ctrl_i.is_byte_op_c;
          state_d      = (!ctrl_i.is_byte_op_c && addr_i[1:0] != 2'b00) ? ERR : REQ;
        end
      end
      REQ: begin
        if (dmem_req_ready_i) state_d = is_load_q ? WAIT : IDLE;
      end
      WAIT: begin
        if (dmem_resp_valid_i) begin
          wb_valid_d = writes_rf_q;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
          state_d    = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      is_store_q   <= 1'b0;
      is_load_q    <= 1'b0;
      writes_rf_q  <= 1'b0;
      is_byte_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q      <= state_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      is_store_q   <= is_store_d;
      is_load_q    <= is_load_d;
      writes_rf_q  <= writes_rf_d;
      is_byte_q    <= is_byte_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign stall_o          = (state_q != IDLE) | ((state_q == IDLE) & accept);
  assign dmem_req_valid_o = (state_q == REQ);
  assign dmem_addr_o      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wen_o       = is_store_q;
  assign dmem_wdata_o     = lane_wdata;
  assign dmem_mask_o      = is_store_q ? lane_mask_w : '0;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign misalign_o       = (state_q == ERR);

endmodule

// File: tb/tb_cl_mem_access.sv
// Self-checking bench for cl_mem_access: expected requests and writebacks
// are queued when an instruction is driven and compared by monitors when
// the DUT handshakes a request or pulses wb_valid_o.
module tb_cl_mem_access;
  import cl_mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  ctrl_sigs    ctrl_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_wen_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_mask_o;
  logic        dmem_resp_valid_i;
  logic [31:0] dmem_resp_data_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cl_mem_access dut (
    .clk               (clk),
    .reset             (reset),
    .valid_i           (valid_i),
    .ctrl_i            (ctrl_i),
    .addr_i            (addr_i),
    .store_data_i      (store_data_i),
    .rd_i              (rd_i),
    .stall_o           (stall_o),
    .dmem_req_valid_o  (dmem_req_valid_o),
    .dmem_req_ready_i  (dmem_req_ready_i),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wen_o        (dmem_wen_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_mask_o       (dmem_mask_o),
    .dmem_resp_valid_i (dmem_resp_valid_i),
    .dmem_resp_data_i  (dmem_resp_data_i),
    .wb_valid_o        (wb_valid_o),
    .wb_rd_o           (wb_rd_o),
    .wb_data_o         (wb_data_o),
    .misalign_o        (misalign_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctrl_sigs mk(input bit load, input bit store, input bit byte_op);
    ctrl_sigs c;
    c.is_load_op_c   = load;
    c.op_writes_rf_c = load;
    c.is_mem_op_c    = load | store;
    c.is_store_op_c  = store;
    c.is_byte_op_c   = byte_op;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request monitor: every handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (!reset && dmem_req_valid_o === 1'b1 && dmem_req_ready_i === 1'b1) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", 32'd1, 32'd0);
      end else begin
        req_t r;
        r = req_q.pop_front();
        check("req_addr", dmem_addr_o, r.addr);
        check("req_wen", {31'd0, dmem_wen_o}, {31'd0, r.wen});
        check("req_mask", {28'd0, dmem_mask_o}, {28'd0, r.mask});
        if (r.wen) check("req_wdata", dmem_wdata_o, r.wdata);
      end
    end
  end

  // Writeback monitor: every pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (!reset && wb_valid_o === 1'b1) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t w;
        w = wb_q.pop_front();
        check("wb_rd", {27'd0, wb_rd_o}, {27'd0, w.rd});
        check("wb_data", wb_data_o, w.data);
      end
    end
  end

  // Drive one memory instruction through accept, request, and response.
  task automatic mem_op(input bit load, input bit store, input bit byte_op,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input int rdy_lat, input int rsp_lat,
                        input logic [31:0] rsp, input bit early_rsp, input bit busy_valid);
    req_t r;
    wb_t  w;
    bit   misal;
    logic [1:0] lane;
    lane  = addr[1:0];
    misal = !byte_op && (lane != 2'b00);
    r.addr  = addr & 32'hFFFF_FFFC;
    r.wen   = store;
    r.mask  = store ? (byte_op ? (4'b0001 << lane) : 4'b1111) : 4'b0000;
    r.wdata = byte_op ? {4{data[7:0]}} : data;
    w.rd    = rd;
    w.data  = byte_op ? ((rsp >> (8 * lane)) & 32'h0000_00FF) : rsp;

    valid_i = 1'b1; ctrl_i = mk(load, store, byte_op);
    addr_i = addr; store_data_i = data; rd_i = rd;
    #1 check("accept_stall", {31'd0, stall_o}, 32'd1);
    step();
    valid_i = busy_valid;
    if (busy_valid) begin
      ctrl_i = mk(1'b0, 1'b1, 1'b0); addr_i = 32'h100; store_data_i = 32'hFFFF_FFFF;
    end

    if (misal) begin
      #1;
      check("err_misalign", {31'd0, misalign_o}, 32'd1);
      check("err_no_req", {31'd0, dmem_req_valid_o}, 32'd0);
      check("err_stall", {31'd0, stall_o}, 32'd1);
      valid_i = 1'b0;
      step();
      #1;
      check("err_done_misalign", {31'd0, misalign_o}, 32'd0);
      check("err_done_req", {31'd0, dmem_req_valid_o}, 32'd0);
      check("err_done_stall", {31'd0, stall_o}, 32'd0);
      return;
    end

    req_q.push_back(r);
    if (load) wb_q.push_back(w);

    for (int i = 0; i < rdy_lat; i++) begin
      #1;
      check("hold_req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
      check("hold_stall", {31'd0, stall_o}, 32'd1);
      check("hold_addr", dmem_addr_o, r.addr);
      check("hold_mask", {28'd0, dmem_mask_o}, {28'd0, r.mask});
      if (store) check("hold_wdata", dmem_wdata_o, r.wdata);
      step();
    end
    dmem_req_ready_i = 1'b1;
    dmem_resp_valid_i = early_rsp;
    dmem_resp_data_i = 32'hBAD0_BAD0;
    #1;
    check("hs_req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
    check("hs_stall", {31'd0, stall_o}, 32'd1);
    step();
    dmem_req_ready_i = 1'b0;
    dmem_resp_valid_i = 1'b0;

    if (load) begin
      for (int i = 0; i < rsp_lat; i++) begin
        #1;
        check("wait_stall", {31'd0, stall_o}, 32'd1);
        check("wait_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
        step();
      end
      valid_i = 1'b0;
      dmem_resp_valid_i = 1'b1;
      dmem_resp_data_i = rsp;
      #1 check("rsp_stall", {31'd0, stall_o}, 32'd1);
      step();
      dmem_resp_valid_i = 1'b0;
      #1;
      check("wb_pulse", {31'd0, wb_valid_o}, 32'd1);
      check("wb_stall", {31'd0, stall_o}, 32'd0);
      step();
      #1 check("wb_one_cycle", {31'd0, wb_valid_o}, 32'd0);
    end else begin
      valid_i = 1'b0;
      #1;
      check("st_done_stall", {31'd0, stall_o}, 32'd0);
      check("st_no_wb", {31'd0, wb_valid_o}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; ctrl_i = '0; addr_i = '0; store_data_i = '0; rd_i = '0;
    dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_resp_data_i = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_wdata", dmem_wdata_o, 32'd0);
    check("rst_mask", {28'd0, dmem_mask_o}, 32'd0);
    check("rst_wb", {31'd0, wb_valid_o}, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    step();

    // LW 0x10 minimum latency, LBU 0x13, SB 0x22, SW with ready held low.
    mem_op(1, 0, 0, 32'h10, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF, 0, 0);
    mem_op(1, 0, 1, 32'h13, 32'h0, 5'd7, 0, 0, 32'hAABB_CCDD, 0, 0);
    mem_op(0, 1, 1, 32'h22, 32'h1234_5677, 5'd0, 0, 0, 32'h0, 0, 0);
    mem_op(0, 1, 0, 32'h40, 32'hCAFE_F00D, 5'd0, 3, 0, 32'h0, 0, 0);
    // Misaligned word load is dropped.
    mem_op(1, 0, 0, 32'h06, 32'h0, 5'd3, 0, 0, 32'h1111_1111, 0, 0);
    // Early response while entering WAIT is ignored; busy valid_i is ignored.
    mem_op(1, 0, 1, 32'h51, 32'h0, 5'd12, 1, 2, 32'h0102_A304, 1, 1);

    // Non-memory instruction is ignored.
    valid_i = 1'b1; ctrl_i = mk(0, 0, 0); addr_i = 32'h80;
    #1 check("nonmem_stall", {31'd0, stall_o}, 32'd0);
    step();
    valid_i = 1'b0;
    #1 check("nonmem_no_req", {31'd0, dmem_req_valid_o}, 32'd0);
    step();

    // Reset while waiting for a load response; the late response is dropped.
    valid_i = 1'b1; ctrl_i = mk(1, 0, 0); addr_i = 32'h30; rd_i = 5'd9;
    req_q.push_back('{addr: 32'h30, wen: 1'b0, wdata: 32'h0, mask: 4'b0000});
    step();
    valid_i = 1'b0; dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    #1 check("rw_wait_stall", {31'd0, stall_o}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; dmem_resp_valid_i = 1'b1; dmem_resp_data_i = 32'h5555_5555;
    #1;
    check("rw_stall", {31'd0, stall_o}, 32'd0);
    check("rw_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
    check("rw_addr", dmem_addr_o, 32'd0);
    check("rw_wen", {31'd0, dmem_wen_o}, 32'd0);
    check("rw_mask", {28'd0, dmem_mask_o}, 32'd0);
    check("rw_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rw_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    check("rw_wb_data", wb_data_o, 32'd0);
    check("rw_misalign", {31'd0, misalign_o}, 32'd0);
    step();
    dmem_resp_valid_i = 1'b0;
    #1 check("rw_no_late_wb", {31'd0, wb_valid_o}, 32'd0);
    mem_op(1, 0, 0, 32'h34, 32'h0, 5'd10, 0, 1, 32'h7654_3210, 0, 0);

    // A few random aligned accesses with random latencies.
    for (int n = 0; n < 8; n++) begin
      bit ld, bt;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      bt = 1'($urandom_range(0, 1));
      a  = {$urandom_range(0, 255), 2'b00} | (bt ? 32'($urandom_range(0, 3)) : 32'd0);
      mem_op(ld, !ld, bt, a, $urandom, 5'($urandom_range(1, 31)),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0, 0);
    end

    step(); step();
    check("req_q_drained", req_q.size(), 32'd0);
    check("wb_q_drained", wb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
